wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
// - Shares one Wishbone slave port (the WB-to-AXI bridge input) between NUM_MASTERS Wishbone masters.
// - Round-robin arbitration; a grant is held for the whole wb_cyc of the owner (bus lock).
// - Muxes the owner's request onto the slave; routes ack/err/rty back to the owner only.
// - Sits between CPU/DMA Wishbone masters and the bridge; one bridge, one AXI master port.
// PARAMETERS
// - NUM_MASTERS  4   number of Wishbone masters, 2..8
// - DATA_WIDTH   32  Wishbone data width, multiple of 8
// - ADDR_WIDTH   32  Wishbone address width
// PORTS
// - clk        in   1                  clock, all logic on rising edge
// - rst        in   1                  synchronous, active-high reset
// - m_cyc_i    in   NUM_MASTERS        per-master cycle request
// - m_stb_i    in   NUM_MASTERS        per-master strobe
// - m_we_i     in   NUM_MASTERS        per-master write enable
// - m_adr_i    in   NUM_MASTERS*AW     packed addresses; master k at [k*AW +: AW]
// - m_dat_i    in   NUM_MASTERS*DW     packed write data
// - m_sel_i    in   NUM_MASTERS*DW/8   packed byte selects
// - m_cti_i    in   NUM_MASTERS*3      packed cycle-type ids
// - m_bte_i    in   NUM_MASTERS*2      packed burst-type ext
// - m_ack_o    out  NUM_MASTERS        ack, owner bit only
// - m_err_o    out  NUM_MASTERS        err, owner bit only
// - m_rty_o    out  NUM_MASTERS        rty, owner bit only
// - m_dat_o    out  DW                 read data, broadcast to all masters
// - s_cyc_o, s_stb_o, s_we_o  out  1   to slave, from owner
// - s_adr_o    out  AW                 to slave
// - s_dat_o    out  DW                 to slave
// - s_sel_o    out  DW/8               to slave
// - s_cti_o    out  3                  to slave
// - s_bte_o    out  2                  to slave
// - s_ack_i, s_err_i, s_rty_i  in  1   from slave
// - s_dat_i    in   DW                 from slave
// - gnt_o      out  NUM_MASTERS        registered one-hot grant (all-zero = idle)
// BEHAVIOUR
// - State: gnt (one-hot register) and last (index of the most recent owner). FSM states:
//   - IDLE: gnt == 0.
//   - OWNED: one gnt bit set.
// - Reset: gnt = 0 and last = NUM_MASTERS-1, so master 0 has first priority.
//   - All s_* control outputs are 0; m_ack/err/rty = 0.
//   - s_adr/dat/sel/cti/bte = 0 while idle.
// - Arbitration edge: any edge where the state is IDLE, or where the owner's m_cyc_i == 0.
//   - At that edge, gnt <= first requester (m_cyc_i bit set) scanning last+1, last+2, ... with wrap mod NUM_MASTERS.
//   - last <= that requester's index.
//   - If there is no requester: gnt <= 0 and last is unchanged.
//   - The owner re-wins only if no other master requests.
// - Latency: request seen at edge t -> gnt and s_cyc_o high after edge t (1 cycle).
// - Handoff: owner drops cyc while another master requests -> new owner is granted at the same edge. No dead cycle.
// - While OWNED, the owner's cyc/stb/we/adr/dat/sel/cti/bte pass combinationally to s_*.
//   - s_cyc_o = |(gnt & m_cyc_i); s_stb_o is gated the same way.
// - The owner keeps the grant for as long as m_cyc_i stays high, including multiple strobes and bursts.
//   - No preemption.
// - s_ack_i/s_err_i/s_rty_i drive only the owner's bit of m_ack_o/m_err_o/m_rty_o (combinational).
//   - When idle, these are dropped.
// - The owner dropping cyc mid-transfer (stb high, no ack) is a master protocol violation.
//   - The grant is still released at the next edge.
// - Simultaneous requests from several masters: resolved strictly by the RR order.
// - Reset asserted mid-transfer: the grant is dropped at that edge and s_cyc_o goes low the same cycle.
// - Assertion: gnt is one-hot or zero at all times.
// STRUCTURE
// - Package wb_arb_pkg:
//   - cti/bte localparams (CTI_CLASSIC=3'b000, CTI_EOB=3'b111, BTE_LINEAR=2'b00).
//   - function rr_next(req, last) returning a one-hot grant.
// - Sub-module wb_rr_pick: combinational round-robin selector.
//   - Inputs: req[N], last index.
//   - Outputs: onehot[N], idx, any.
// - Top: grant/last registers plus the muxes.
// TESTING
// - Single request:
//   - Stimulus: m1 cyc/stb write adr=0x100 dat=0xDEADBEEF; slave acks 2 cycles later.
//   - Required: gnt_o=0010 one cycle later; s_adr_o=0x100; m_ack_o=0010 only.
// - Simultaneous request after reset:
//   - Stimulus: m0..m3 request together, each holds cyc for one ack.
//   - Required: grant order 0,1,2,3; back-to-back handoff with no idle cycle.
// - Bus lock:
//   - Stimulus: m2 holds cyc for a 4-beat CTI=010 burst while m0 requests.
//   - Required: m0 is granted only on the edge after m2 drops cyc.
// - Fairness:
//   - Stimulus: m0 and m3 request continuously, single transfers.
//   - Required: grants alternate 3,0,3,0.
// - Error path:
//   - Stimulus: slave returns s_err_i on a read by m1.
//   - Required: m_err_o=0010, m_ack_o=0; next request is still served.
// - Reset:
//   - Stimulus: rst asserted with m2 owning the bus.
//   - Required: gnt_o=0 and s_cyc_o=0 after the edge; post-reset, m0 has first priority.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants, state type and round-robin helper for the Wishbone arbiter
package wb_arb_pkg;
    localparam int MAX_N = 8;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    typedef enum logic {IDLE, OWNED} arb_state_t;
    // Scan downwards so the requester closest after last is the one left standing.
    function automatic logic [MAX_N-1:0] rr_next(input logic [MAX_N-1:0] req, input logic [2:0] last, input int n);
        logic [MAX_N-1:0] g;
        logic [2:0] k;
        g = '0;
        for (int i = n; i >= 1; i--) begin
            k = 3'((int'(last) + i) % n);
            if (req[k]) begin
                g = '0;
                g[k] = 1'b1;
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: Wishbone bundle for N packed masters (N=1 gives a plain slave link)
interface wb_rr_arbiter_if #(
    parameter int N = 1,
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [N-1:0] cyc;
    logic [N-1:0] stb;
    logic [N-1:0] we;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] dat_w;
    logic [N*DW/8-1:0] sel;
    logic [N*3-1:0] cti;
    logic [N*2-1:0] bte;
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [N-1:0] rty;
    logic [DW-1:0] dat_r;
    modport master (output cyc, stb, we, adr, dat_w, sel, cti, bte, input ack, err, rty, dat_r);
    modport slave (input cyc, stb, we, adr, dat_w, sel, cti, bte, output ack, err, rty, dat_r);
endinterface

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin selector starting just after the last owner
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [MAX_N-1:0] full;
    assign full = rr_next(MAX_N'(req), 3'(last), N);
    assign onehot = full[N-1:0];
    assign any = |full;
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (onehot[i]) idx = IW'(i);
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, grant locked for the owner's whole cycle
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_rr_arbiter_if.slave         m,
    wb_rr_arbiter_if.master        s,
    output logic [NUM_MASTERS-1:0] gnt
);
    localparam int N = NUM_MASTERS;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(N);
    arb_state_t state, next_state;
    logic [IW-1:0] last, pick_idx;
    logic [N-1:0] pick_gnt;
    logic pick_any, arb_edge, own;
    logic [AW-1:0] adr_a [N];
    logic [DW-1:0] dat_a [N];
    logic [SW-1:0] sel_a [N];
    logic [2:0] cti_a [N];
    logic [1:0] bte_a [N];
    wb_rr_pick #(.N(N)) pick (
        .req(m.cyc),
        .last(last),
        .onehot(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );
    // Re-arbitrate whenever nobody holds the bus; a live owner keeps it (bus lock).
    always_comb begin
        arb_edge = 1'b0;
        next_state = state;
        arb_edge = (state == IDLE) || !(|(gnt & m.cyc));
        next_state = arb_edge ? (pick_any ? OWNED : IDLE) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            last <= IW'(N - 1);
        end else begin
            state <= next_state;
            if (arb_edge) begin
                gnt <= pick_gnt;
                if (pick_any) last <= pick_idx;
            end
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign adr_a[g] = m.adr[g*AW +: AW];
        assign dat_a[g] = m.dat_w[g*DW +: DW];
        assign sel_a[g] = m.sel[g*SW +: SW];
        assign cti_a[g] = m.cti[g*3 +: 3];
        assign bte_a[g] = m.bte[g*2 +: 2];
    end
    // While owned, last always names the owner, so it doubles as the mux select.
    assign own = (state == OWNED);
    assign s.cyc = |(gnt & m.cyc);
    assign s.stb = |(gnt & m.stb);
    assign s.we = |(gnt & m.we);
    assign s.adr = own ? adr_a[last] : '0;
    assign s.dat_w = own ? dat_a[last] : '0;
    assign s.sel = own ? sel_a[last] : '0;
    assign s.cti = own ? cti_a[last] : CTI_CLASSIC;
    assign s.bte = own ? bte_a[last] : BTE_LINEAR;
    assign m.ack = gnt & {N{s.ack}};
    assign m.err = gnt & {N{s.err}};
    assign m.rty = gnt & {N{s.rty}};
    assign m.dat_r = s.dat_r;
    always_ff @(posedge clk) begin
        assert ($onehot0(gnt));
        assert ((state == OWNED) == (|gnt));
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed + random stimulus checked against a queue-free round-robin model
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;
    localparam int N = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] gnt;
    int checks = 0;
    int errors = 0;
    int owner = -1;
    int last_m = N - 1;
    wb_rr_arbiter_if #(.N(N), .DW(DW), .AW(AW)) mif ();
    wb_rr_arbiter_if #(.N(1), .DW(DW), .AW(AW)) sif ();
    wb_rr_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .m(mif.slave),
        .s(sif.master),
        .gnt(gnt)
    );
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive(int k, bit c, bit st, bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [2:0] ct);
        mif.cyc[k] = c;
        mif.stb[k] = st;
        mif.we[k] = w;
        mif.adr[k*AW +: AW] = a;
        mif.dat_w[k*DW +: DW] = d;
        mif.sel[k*4 +: 4] = 4'($urandom);
        mif.cti[k*3 +: 3] = ct;
        mif.bte[k*2 +: 2] = 2'($urandom);
    endtask

    task automatic slave(bit a, bit e, bit r);
        sif.ack = a;
        sif.err = e;
        sif.rty = r;
        sif.dat_r = $urandom;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        bit o;
        int ow;
        o = owner >= 0;
        ow = o ? owner : 0;
        eg = o ? oh(owner) : '0;
        check("gnt", gnt, eg);
        check("s_cyc", sif.cyc, o ? mif.cyc[ow] : 1'b0);
        check("s_stb", sif.stb, o ? mif.stb[ow] : 1'b0);
        check("s_we", sif.we, o ? mif.we[ow] : 1'b0);
        check("s_adr", sif.adr, o ? mif.adr[ow*AW +: AW] : '0);
        check("s_dat", sif.dat_w, o ? mif.dat_w[ow*DW +: DW] : '0);
        check("s_sel", sif.sel, o ? mif.sel[ow*4 +: 4] : '0);
        check("s_cti", sif.cti, o ? mif.cti[ow*3 +: 3] : CTI_CLASSIC);
        check("s_bte", sif.bte, o ? mif.bte[ow*2 +: 2] : BTE_LINEAR);
        check("m_ack", mif.ack, sif.ack ? eg : '0);
        check("m_err", mif.err, sif.err ? eg : '0);
        check("m_rty", mif.rty, sif.rty ? eg : '0);
        check("m_dat", mif.dat_r, sif.dat_r);
    endtask

    // Reference: owner is released only when its cyc is low; next owner is the first
    // requester found walking forward from the previous owner, wrapping mod N.
    task automatic model_edge();
        if (rst) begin
            owner = -1;
            last_m = N - 1;
        end else if (owner < 0 || !mif.cyc[owner]) begin
            owner = -1;
            for (int i = 1; i <= N; i++)
                if (owner < 0 && mif.cyc[(last_m + i) % N]) owner = (last_m + i) % N;
            if (owner >= 0) last_m = owner;
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        mif.cyc = '0;
        mif.stb = '0;
        mif.we = '0;
        mif.adr = '0;
        mif.dat_w = '0;
        mif.sel = '0;
        mif.cti = '0;
        mif.bte = '0;
        slave(0, 0, 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        step();
        check("rst_gnt", gnt, '0);
        check("rst_cyc", sif.cyc, 1'b0);
        rst = 1'b0;
        // single request by m1
        drive(1, 1, 1, 1, 32'h100, 32'hDEADBEEF, CTI_CLASSIC);
        step();
        check("single_gnt", gnt, 4'b0010);
        step();
        slave(1, 0, 0);
        #1;
        check("single_ack", mif.ack, 4'b0010);
        check("single_adr", sif.adr, 32'h100);
        check("single_dat", sif.dat_w, 32'hDEADBEEF);
        step();
        slave(0, 0, 0);
        drive(1, 0, 0, 0, '0, '0, CTI_CLASSIC);
        step();
        step();
        // simultaneous requests right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < N; k++) drive(k, 1, 1, 0, 32'h200 + 32'(k), '0, CTI_CLASSIC);
        step();
        for (int i = 0; i < N; i++) begin
            check("rr_order", gnt, oh(i));
            slave(1, 0, 0);
            step();
            slave(0, 0, 0);
            drive(i, 0, 0, 0, '0, '0, CTI_CLASSIC);
            check("no_gap", gnt, oh(i));
            step();
        end
        check("rr_idle", gnt, '0);
        // bus lock: m2 burst while m0 waits
        drive(2, 1, 1, 1, 32'h500, 32'h1, CTI_INCR);
        step();
        drive(0, 1, 1, 0, 32'h600, '0, CTI_CLASSIC);
        for (int b = 0; b < 4; b++) begin
            drive(2, 1, 1, 1, 32'h500 + 32'(4 * b), 32'(b), b == 3 ? CTI_EOB : CTI_INCR);
            slave(1, 0, 0);
            check("lock", gnt, 4'b0100);
            step();
        end
        slave(0, 0, 0);
        drive(2, 0, 0, 0, '0, '0, CTI_CLASSIC);
        check("lock_hold", gnt, 4'b0100);
        step();
        check("lock_handoff", gnt, 4'b0001);
        slave(1, 0, 0);
        step();
        slave(0, 0, 0);
        drive(0, 0, 0, 0, '0, '0, CTI_CLASSIC);
        step();
        step();
        // fairness between m0 and m3 (last owner is m0 here)
        drive(0, 1, 1, 0, 32'h700, '0, CTI_CLASSIC);
        drive(3, 1, 1, 0, 32'h730, '0, CTI_CLASSIC);
        step();
        for (int j = 0; j < 4; j++) begin
            int e;
            e = (j % 2 == 0) ? 3 : 0;
            check("fair", gnt, oh(e));
            slave(1, 0, 0);
            step();
            slave(0, 0, 0);
            drive(e, 0, 0, 0, '0, '0, CTI_CLASSIC);
            step();
            drive(e, 1, 1, 0, 32'h700 + 32'(e * 16), '0, CTI_CLASSIC);
        end
        drive(0, 0, 0, 0, '0, '0, CTI_CLASSIC);
        drive(3, 0, 0, 0, '0, '0, CTI_CLASSIC);
        step();
        step();
        // error path on a read by m1
        drive(1, 1, 1, 0, 32'h300, '0, CTI_CLASSIC);
        step();
        step();
        slave(0, 1, 0);
        #1;
        check("err_route", mif.err, 4'b0010);
        check("err_noack", mif.ack, 4'b0000);
        step();
        slave(0, 0, 0);
        drive(1, 0, 0, 0, '0, '0, CTI_CLASSIC);
        drive(2, 1, 1, 1, 32'h400, 32'h55, CTI_CLASSIC);
        step();
        check("after_err", gnt, 4'b0100);
        // reset while m2 owns the bus
        rst = 1'b1;
        step();
        check("rst_mid_gnt", gnt, '0);
        check("rst_mid_cyc", sif.cyc, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < N; k++) drive(k, 1, 1, 0, 32'h800 + 32'(k), '0, CTI_CLASSIC);
        step();
        check("rst_prio", gnt, 4'b0001);
        for (int k = 0; k < N; k++) drive(k, 0, 0, 0, '0, '0, CTI_CLASSIC);
        step();
        step();
        // random traffic
        for (int c = 0; c < 2000; c++) begin
            int r;
            for (int k = 0; k < N; k++) begin
                bit cy;
                cy = mif.cyc[k] ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
                drive(k, cy, cy && $urandom_range(0, 1) == 1, 1'($urandom), $urandom, $urandom, 3'($urandom));
            end
            r = $urandom_range(0, 5);
            slave(r == 0 || r == 1, r == 2, r == 3);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
